// File: rtl/ps2_key_rx.sv
`timescale 1ns/1ps
// ps2_key_rx: PS/2 keyboard receiver in the clk25 domain.
// Synchronizes and filters the raw PS/2 clock, deserializes 11-bit
// device-to-host frames (start, 8 data LSB-first, odd parity, stop),
// decodes E0/F0 prefixes and counts accepted make codes in kcount.
//
// Ports:
//   clk25      in   system clock, 25 MHz
//   rst        in   asynchronous, active-high reset
//   ps2_clk    in   raw PS/2 clock (asynchronous)
//   ps2_data   in   raw PS/2 data (asynchronous)
//   kcount     out  [7:0] accepted make codes, wraps modulo 256
//   scancode   out  [7:0] last accepted make code
//   extended   out  last accepted make code was E0-prefixed
//   key_valid  out  one-cycle pulse per accepted make code
//   frame_err  out  one-cycle pulse on start/parity/stop error or timeout
//
// Optional build macro PS2_TYPEMATIC_FILTER_EN: suppresses auto-repeat
// make codes that match the currently held key until it is released.
module ps2_key_rx #(
    parameter int unsigned FILTER_LEN  = 8,
    parameter int unsigned TIMEOUT_CYC = 25000
) (
    input  logic       clk25,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] kcount,
    output logic [7:0] scancode,
    output logic       extended,
    output logic       key_valid,
    output logic       frame_err
);

    localparam int unsigned FCNT_W   = $clog2(FILTER_LEN + 1);
    localparam int unsigned TMO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [7:0]  CODE_EXT = 8'hE0;
    localparam logic [7:0]  CODE_BRK = 8'hF0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // Two-flop synchronizers; lines idle high
    logic clk_s1_q, clk_s2_q;
    logic dat_s1_q, dat_s2_q;

    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            clk_s1_q <= 1'b1;
            clk_s2_q <= 1'b1;
            dat_s1_q <= 1'b1;
            dat_s2_q <= 1'b1;
        end else begin
            clk_s1_q <= ps2_clk;
            clk_s2_q <= clk_s1_q;
            dat_s1_q <= ps2_data;
            dat_s2_q <= dat_s1_q;
        end
    end

    // Clock glitch filter: level changes after FILTER_LEN consecutive
    // samples that disagree with the current filtered level
    logic              filt_q, filt_d;
    logic              filt_dly_q;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    logic              fe_c;

    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        if (clk_s2_q != filt_q) begin
            if (fcnt_q == FCNT_W'(FILTER_LEN - 1)) begin
                filt_d = clk_s2_q;
            end else begin
                fcnt_d = fcnt_q + FCNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            filt_q     <= 1'b1;
            filt_dly_q <= 1'b1;
            fcnt_q     <= '0;
        end else begin
            filt_q     <= filt_d;
            filt_dly_q <= filt_q;
            fcnt_q     <= fcnt_d;
        end
    end

    // Falling edge of the filtered clock
    assign fe_c = filt_dly_q & ~filt_q;

    // Frame FSM, timeout and decode state
    state_t           state_q, state_d;
    logic [2:0]       bitcnt_q, bitcnt_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             par_q, par_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             brk_q, brk_d;
    logic             ext_q, ext_d;
    logic [7:0]       kcount_q, kcount_d;
    logic [7:0]       scancode_q, scancode_d;
    logic             extended_q, extended_d;
    logic             key_valid_q, key_valid_d;
    logic             frame_err_q, frame_err_d;
    logic             good_c;
`ifdef PS2_TYPEMATIC_FILTER_EN
    logic [7:0]       held_q, held_d;
    logic             held_ext_q, held_ext_d;
`endif

    // Stop bit high and odd parity over data plus parity bit
    assign good_c = dat_s2_q & (^{shreg_q, par_q});

    always_comb begin
        state_d     = state_q;
        bitcnt_d    = bitcnt_q;
        shreg_d     = shreg_q;
        par_d       = par_q;
        brk_d       = brk_q;
        ext_d       = ext_q;
        kcount_d    = kcount_q;
        scancode_d  = scancode_q;
        extended_d  = extended_q;
        key_valid_d = 1'b0;
        frame_err_d = 1'b0;
`ifdef PS2_TYPEMATIC_FILTER_EN
        held_d      = held_q;
        held_ext_d  = held_ext_q;
`endif

        // Idle-time counter restarts on every clock edge inside a frame
        if (fe_c || (state_q == S_IDLE)) begin
            tmo_d = '0;
        end else begin
            tmo_d = tmo_q + TMO_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (fe_c) begin
                    if (!dat_s2_q) begin
                        state_d  = S_DATA;
                        bitcnt_d = '0;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (fe_c) begin
                    shreg_d  = {dat_s2_q, shreg_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) begin
                        state_d = S_PARITY;
                    end
                end
            end
            S_PARITY: begin
                if (fe_c) begin
                    par_d   = dat_s2_q;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (fe_c) begin
                    state_d = S_IDLE;
                    if (!good_c) begin
                        frame_err_d = 1'b1;
                        brk_d       = 1'b0;
                        ext_d       = 1'b0;
                    end else if (shreg_q == CODE_EXT) begin
                        ext_d = 1'b1;
                    end else if (shreg_q == CODE_BRK) begin
                        brk_d = 1'b1;
                    end else if (brk_q) begin
                        // Release of a key: consumes both prefixes
                        brk_d = 1'b0;
                        ext_d = 1'b0;
`ifdef PS2_TYPEMATIC_FILTER_EN
                        if ((shreg_q == held_q) && (ext_q == held_ext_q)) begin
                            held_d     = 8'h00;
                            held_ext_d = 1'b0;
                        end
`endif
                    end else begin
                        ext_d = 1'b0;
`ifdef PS2_TYPEMATIC_FILTER_EN
                        if (!((shreg_q == held_q) && (ext_q == held_ext_q))) begin
                            key_valid_d = 1'b1;
                            scancode_d  = shreg_q;
                            extended_d  = ext_q;
                            kcount_d    = kcount_q + 8'd1;
                            held_d      = shreg_q;
                            held_ext_d  = ext_q;
                        end
`else
                        key_valid_d = 1'b1;
                        scancode_d  = shreg_q;
                        extended_d  = ext_q;
                        kcount_d    = kcount_q + 8'd1;
`endif
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort a stalled frame; prefix flags survive, partial byte does not
        if ((state_q != S_IDLE) && !fe_c && (tmo_q == TMO_W'(TIMEOUT_CYC - 1))) begin
            state_d     = S_IDLE;
            shreg_d     = '0;
            frame_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            bitcnt_q    <= '0;
            shreg_q     <= '0;
            par_q       <= 1'b0;
            tmo_q       <= '0;
            brk_q       <= 1'b0;
            ext_q       <= 1'b0;
            kcount_q    <= '0;
            scancode_q  <= '0;
            extended_q  <= 1'b0;
            key_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef PS2_TYPEMATIC_FILTER_EN
            held_q      <= '0;
            held_ext_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            shreg_q     <= shreg_d;
            par_q       <= par_d;
            tmo_q       <= tmo_d;
            brk_q       <= brk_d;
            ext_q       <= ext_d;
            kcount_q    <= kcount_d;
            scancode_q  <= scancode_d;
            extended_q  <= extended_d;
            key_valid_q <= key_valid_d;
            frame_err_q <= frame_err_d;
`ifdef PS2_TYPEMATIC_FILTER_EN
            held_q      <= held_d;
            held_ext_q  <= held_ext_d;
`endif
        end
    end

    assign kcount    = kcount_q;
    assign scancode  = scancode_q;
    assign extended  = extended_q;
    assign key_valid = key_valid_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_key_rx.sv
`timescale 1ns/1ps
// tb_ps2_key_rx: drives PS/2 frames into ps2_key_rx and checks every output
// on every cycle against a frame-level model of the receiver.
module tb_ps2_key_rx;

    localparam int unsigned FILTER_LEN  = 8;
    localparam int unsigned TIMEOUT_CYC = 25000;
    // Line fall -> 2 sync flops -> FILTER_LEN filter samples -> output register
    localparam int LAT  = 2 + FILTER_LEN + 1;
    localparam int HALF = 9;

    logic       clk25 = 1'b0;
    logic       rst;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] kcount;
    logic [7:0] scancode;
    logic       extended;
    logic       key_valid;
    logic       frame_err;

    ps2_key_rx #(
        .FILTER_LEN (FILTER_LEN),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk25    (clk25),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .kcount   (kcount),
        .scancode (scancode),
        .extended (extended),
        .key_valid(key_valid),
        .frame_err(frame_err)
    );

    always #20 clk25 = ~clk25;

    int cyc     = 0;
    int n_cmp   = 0;
    int n_bad   = 0;
    int kv_seen = 0;
    int fe_seen = 0;

    typedef struct {
        int         at;
        bit         kv;
        bit         ferr;
        logic [7:0] kc;
        logic [7:0] sc;
        bit         ex;
    } ev_t;
    ev_t evq[$];

    // Model state: visible outputs and hidden decode flags
    logic [7:0] m_kcount, m_scan, m_held;
    bit         m_xout, m_ext, m_brk, m_held_ext;
    // Expected persistent outputs as currently visible
    logic [7:0] e_kc, e_sc;
    bit         e_ex;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void push_ev(input int at, input bit kv, input bit ferr);
        ev_t e;
        e.at = at; e.kv = kv; e.ferr = ferr;
        e.kc = m_kcount; e.sc = m_scan; e.ex = m_xout;
        evq.push_back(e);
    endfunction

    function automatic void model_reset();
        m_kcount = '0; m_scan = '0; m_held = '0;
        m_xout = 0; m_ext = 0; m_brk = 0; m_held_ext = 0;
        e_kc = '0; e_sc = '0; e_ex = 0;
        evq.delete();
    endfunction

    // Effect of one complete frame whose stop bit fell at cycle 'fall'
    function automatic void model_frame(input logic [7:0] b, input bit par, input bit stop, input int fall);
        bit good;
        bit accept;
        good = stop && ((^b ^ par) == 1'b1);
        if (!good) begin
            m_brk = 0; m_ext = 0;
            push_ev(fall + LAT, 0, 1);
        end else if (b == 8'hE0) begin
            m_ext = 1;
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else if (m_brk) begin
            if (b == m_held && m_ext == m_held_ext) begin
                m_held = '0; m_held_ext = 0;
            end
            m_brk = 0; m_ext = 0;
        end else begin
            accept = 1;
`ifdef PS2_TYPEMATIC_FILTER_EN
            if (b == m_held && m_ext == m_held_ext) accept = 0;
`endif
            if (accept) begin
                m_kcount = m_kcount + 8'd1;
                m_scan = b; m_xout = m_ext;
                m_held = b; m_held_ext = m_ext;
                push_ev(fall + LAT, 1, 0);
            end
            m_ext = 0;
        end
    endfunction

    // Per-cycle comparison against the model
    always @(posedge clk25) begin
        bit ekv, efe;
        ev_t e;
        cyc = cyc + 1;
        #1;
        ekv = 0; efe = 0;
        while (evq.size() > 0 && evq[0].at < cyc) begin
            e = evq.pop_front();
            n_cmp++; n_bad++;
            $display("FAIL sched: event for cycle %0d skipped (now %0d)", e.at, cyc);
        end
        if (evq.size() > 0 && evq[0].at == cyc) begin
            e = evq.pop_front();
            ekv = e.kv; efe = e.ferr;
            e_kc = e.kc; e_sc = e.sc; e_ex = e.ex;
        end
        chk("key_valid", 32'(key_valid), 32'(ekv));
        chk("frame_err", 32'(frame_err), 32'(efe));
        chk("kcount",    32'(kcount),    32'(e_kc));
        chk("scancode",  32'(scancode),  32'(e_sc));
        chk("extended",  32'(extended),  32'(e_ex));
        if (key_valid === 1'b1) kv_seen++;
        if (frame_err === 1'b1) fe_seen++;
    end

    task automatic bit_fall(input bit d, output int fall);
        ps2_data = d;
        repeat (4) @(negedge clk25);
        ps2_clk = 1'b0;
        fall = cyc;
    endtask

    task automatic bit_rise();
        repeat (HALF) @(negedge clk25);
        ps2_clk = 1'b1;
        repeat (HALF - 4) @(negedge clk25);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit par_flip, input bit stop);
        logic [10:0] bits;
        bit par;
        int f;
        par  = (~^b) ^ par_flip;
        bits = {stop, par, b, 1'b0};
        for (int i = 0; i < 11; i++) begin
            bit_fall(bits[i], f);
            if (i == 10) model_frame(b, par, stop, f);
            bit_rise();
        end
    endtask

    task automatic send_partial(input logic [7:0] b, input int n, output int last_fall);
        logic [8:0] bits;
        bits = {b, 1'b0};
        for (int i = 0; i <= n; i++) begin
            bit_fall(bits[i], last_fall);
            bit_rise();
        end
    endtask

    initial begin
        #8_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lf;
        int r;
        logic [7:0] b;
        logic [7:0] last_b;
        int base;

        rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
        model_reset();
        repeat (5) @(negedge clk25);
        chk("rst_kcount",    32'(kcount),    32'h0);
        chk("rst_scancode",  32'(scancode),  32'h0);
        chk("rst_extended",  32'(extended),  32'h0);
        chk("rst_key_valid", 32'(key_valid), 32'h0);
        chk("rst_frame_err", 32'(frame_err), 32'h0);
        rst = 1'b0;
        repeat (20) @(negedge clk25);

        // Plain make code
        send_frame(8'h1C, 0, 1);
        chk("mk1C_kv",   32'(kv_seen),  32'd1);
        chk("mk1C_sc",   32'(scancode), 32'h1C);
        chk("mk1C_ext",  32'(extended), 32'h0);
        chk("mk1C_kcnt", 32'(kcount),   32'h01);

        // Release then extended make
        send_frame(8'hF0, 0, 1);
        send_frame(8'h1C, 0, 1);
        chk("brk_kv",   32'(kv_seen), 32'd1);
        chk("brk_kcnt", 32'(kcount),  32'h01);
        send_frame(8'hE0, 0, 1);
        send_frame(8'h75, 0, 1);
        chk("ext_kv",   32'(kv_seen),  32'd2);
        chk("ext_sc",   32'(scancode), 32'h75);
        chk("ext_ext",  32'(extended), 32'h1);
        chk("ext_kcnt", 32'(kcount),   32'h02);

        // Parity error, then a good frame
        send_frame(8'h1C, 1, 1);
        chk("par_fe",   32'(fe_seen), 32'd1);
        chk("par_kv",   32'(kv_seen), 32'd2);
        chk("par_kcnt", 32'(kcount),  32'h02);
        send_frame(8'h32, 0, 1);
        chk("g32_kv",   32'(kv_seen),  32'd3);
        chk("g32_sc",   32'(scancode), 32'h32);
        chk("g32_ext",  32'(extended), 32'h0);
        chk("g32_kcnt", 32'(kcount),   32'h03);

        // Stop bit error
        send_frame(8'h41, 0, 0);
        chk("stop_fe",   32'(fe_seen), 32'd2);
        chk("stop_kcnt", 32'(kcount),  32'h03);

        // Timeout after 4 data bits
        send_partial(8'h1C, 4, lf);
        push_ev(lf + LAT + TIMEOUT_CYC, 0, 1);
        repeat (TIMEOUT_CYC + 40) @(negedge clk25);
        chk("tmo_fe", 32'(fe_seen), 32'd3);
        send_frame(8'h1C, 0, 1);
        chk("tmo_next_sc",   32'(scancode), 32'h1C);
        chk("tmo_next_kcnt", 32'(kcount),   32'h04);

        // Randomized mix of makes, extended makes, releases and bad frames
        last_b = 8'h1C;
        for (int k = 0; k < 16; k++) begin
            r = int'($urandom_range(9, 0));
            b = 8'($urandom_range(255, 1));
            if (b == 8'hE0 || b == 8'hF0) b = 8'h2A;
            case (r)
                0, 1, 2, 3: send_frame(b, 0, 1);
                4: begin b = last_b; send_frame(b, 0, 1); end
                5, 6: begin send_frame(8'hE0, 0, 1); send_frame(b, 0, 1); end
                7: begin send_frame(8'hF0, 0, 1); send_frame(b, 0, 1); end
                8: begin send_frame(8'hE0, 0, 1); send_frame(8'hF0, 0, 1); send_frame(b, 0, 1); end
                default: send_frame(b, 1, 1);
            endcase
            last_b = b;
        end

        // Random make codes up to kcount=FF, then one more wraps to 00
        for (int k = 0; k < 600 && m_kcount != 8'hFF; k++) begin
            b = 8'($urandom_range(255, 1));
            if (b == 8'hE0 || b == 8'hF0) b = 8'h2A;
            send_frame(b, 0, 1);
        end
        chk("preload_kcnt", 32'(kcount), 32'hFF);
        b = (m_held == 8'h5A) ? 8'h5B : 8'h5A;
        send_frame(b, 0, 1);
        chk("wrap_kcnt", 32'(kcount), 32'h00);

        // Reset in the middle of a frame
        send_partial(8'h1C, 4, lf);
        rst = 1'b1;
        model_reset();
        repeat (3) @(negedge clk25);
        chk("mrst_kcount",   32'(kcount),    32'h0);
        chk("mrst_scancode", 32'(scancode),  32'h0);
        chk("mrst_extended", 32'(extended),  32'h0);
        chk("mrst_kv",       32'(key_valid), 32'h0);
        rst = 1'b0;
        repeat (20) @(negedge clk25);

        // Typematic sequence 1C,1C,1C,F0,1C,1C from reset
        base = kv_seen;
        send_frame(8'h1C, 0, 1);
        send_frame(8'h1C, 0, 1);
        send_frame(8'h1C, 0, 1);
        send_frame(8'hF0, 0, 1);
        send_frame(8'h1C, 0, 1);
        send_frame(8'h1C, 0, 1);
`ifdef PS2_TYPEMATIC_FILTER_EN
        chk("typ_kcnt", 32'(kcount), 32'h02);
        chk("typ_kv",   32'(kv_seen - base), 32'd2);
`else
        chk("typ_kcnt", 32'(kcount), 32'h04);
        chk("typ_kv",   32'(kv_seen - base), 32'd4);
`endif
        chk("typ_sc", 32'(scancode), 32'h1C);

        repeat (20) @(negedge clk25);
        chk("queue_drained", 32'(evq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
